light_sequencer: RTL
====================

# light_sequencer

Autonomous traffic-light driver for the red-light/green-light race game. It generates the green → yellow → red light sequence the car logic consumes: the 2-bit light code and a 1-bit `red` level. This replaces the manual push-button light toggle with timed phases, and green duration is randomised by an LFSR. A manual mode keeps button-driven stepping for demo and debug.

## Interface
- `TICK_DIV`, 4: clk cycles per phase tick, ≥2.
- `GREEN_MIN`, 2: minimum green length in ticks, 1..192.
- `GREEN_MASK`, 8'h03: AND-mask on the LFSR added to green length; 0 gives a fixed green.
- `YELLOW_TICKS`, 1: yellow length in ticks, ≥1.
- `RED_TICKS`, 3: red length in ticks, ≥1.
- `LFSR_SEED`, 8'h5A: LFSR reset value; 0 is replaced by 8'h01.
- `clk`  in  1  system clock, sole clock domain.
- `rst`  in  1  reset; asynchronous, active-low.
- `enable`  in  1  1 = sequence runs; 0 = idle.
- `manual`  in  1  1 = phases advance only on `step` release; 0 = timed.
- `step`  in  1  raw level-held push button; acts on release.
- `out_red_light`  out  2  light code: 01 green, 11 yellow, 10 red.
- `red`  out  1  1 only while in RED.
- `phase_pulse`  out  1  one-cycle pulse on every phase change.
- `round_count`  out  8  completed RED→GREEN cycles, wraps 255→0.

## Operation
- Reset values:
  - state IDLE, `out_red_light`=01, `red`=0, `phase_pulse`=0, `round_count`=0.
  - LFSR=seed, divider=0, remaining=0, step flag=0.
- State transitions:
  - IDLE→GREEN at the first edge with `enable`=1.
  - GREEN→YELLOW, YELLOW→RED, RED→GREEN.
- Light code per state: IDLE shows 01; GREEN 01; YELLOW 11; RED 10.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - Advances every clk while not in reset.
  - Never reaches 0.
- Phase length is loaded on entry:
  - GREEN: GREEN_MIN + (lfsr & GREEN_MASK), 8-bit, saturating at 255.
  - YELLOW: YELLOW_TICKS.
  - RED: RED_TICKS.
- Timed mode (`manual`=0):
  - Each tick decrements `remaining`.
  - A tick arriving with `remaining`=1 moves to the next state.
  - The phase therefore lasts exactly length×TICK_DIV cycles.
- Manual mode (`manual`=1):
  - Step flag sets on `step`=1.
  - At the first edge with flag=1 and `step`=0, advance one state and clear the flag.
  - Ticks are ignored.
- In timed mode the step flag is held at 0, so presses are discarded.
- `round_count` increments on each RED→GREEN transition only.
- `enable`→0 in any state: IDLE at the next edge, with divider and remaining cleared. `round_count` is kept.
- `manual` 1→0 mid-phase: stay in the current state, reload its full length, restart the divider.
- `manual` 0→1 mid-phase: stay in the current state and freeze `remaining`.
- `enable`=0 takes priority over a simultaneous tick or step release.

## Timing
- All outputs are registered and update on the transition edge itself; there is no extra output stage.
- `red` and `out_red_light` change on the same edge as the state.
- `phase_pulse` is high for exactly the one cycle following each state change, IDLE→GREEN included.
- Divider:
  - Restarts at 0 on every phase entry.
  - Tick asserts on the cycle the count equals TICK_DIV-1.
  - First tick comes TICK_DIV cycles after entry.
- Manual latency: the state changes one edge after `step` is sampled low.
- `rst` asserted mid-phase forces the reset values immediately (asynchronous). Sequencing resumes from IDLE after release.

## Structure
- Package `light_pkg` holds:
  - state enum (IDLE, GREEN, YELLOW, RED);
  - light codes LIGHT_GREEN=2'b01, LIGHT_YELLOW=2'b11, LIGHT_RED=2'b10;
  - LFSR tap constant.
- Sub-module `tick_divider` (params TICK_DIV; ports clk, rst, clear, tick), with counter width $clog2(TICK_DIV).
- FSM, length loader, LFSR and step detector live in the top module.

## Test plan
- Reset, then `enable`=1 with defaults and GREEN_MASK=0:
  - GREEN 8 cycles, YELLOW 4, RED 12, then GREEN.
  - `round_count`=1 after the first RED→GREEN.
  - `phase_pulse` fires 4 times across that cycle.
- GREEN_MASK=8'h03 over 50 rounds: every green lasts 8..20 cycles, and more than one distinct length is observed.
- `manual`=1, press/release `step` 3 times (each press held 5 cycles):
  - light 01→11→10→01, one edge after each release.
  - No change during any hold.
- `enable` dropped mid-RED:
  - next edge shows IDLE, light 01, `red`=0, `round_count` unchanged.
  - Re-enable gives GREEN with a full-length phase.
- `manual` 1→0 while in YELLOW with `remaining` frozen: YELLOW lasts a full 4 cycles from the switch.
- `rst` pulsed low mid-GREEN after 255 rounds: all outputs return to reset values immediately. A separate run through 256 rounds checks `round_count` wraps 255→0.

Source files
------------

// File: rtl/light_sequencer_pkg.sv
// Shared types and constants for the race-game light sequencer: phase states,
// light codes and the LFSR tap mask.
package light_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2,
        RED    = 2'd3
    } state_t;

    localparam logic [1:0] LIGHT_GREEN  = 2'b01;
    localparam logic [1:0] LIGHT_YELLOW = 2'b11;
    localparam logic [1:0] LIGHT_RED    = 2'b10;

    // x^8 + x^6 + x^5 + x^4 + 1 expressed as bits 7,5,4,3 of the shift register
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [1:0] light_code(input state_t s);
        case (s)
            YELLOW:  return LIGHT_YELLOW;
            RED:     return LIGHT_RED;
            default: return LIGHT_GREEN;
        endcase
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/light_sequencer_tick_divider.sv
// Phase tick generator: free-running modulo-TICK_DIV counter, restartable with a
// synchronous clear so every phase starts with a fresh divider.
module tick_divider #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);
    localparam int             CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/light_sequencer.sv
// Autonomous green/yellow/red light driver with an LFSR-randomised green phase
// and a manual mode that steps one phase per button release.
module light_sequencer
    import light_pkg::*;
#(
    parameter int         TICK_DIV     = 4,
    parameter int         GREEN_MIN    = 2,
    parameter logic [7:0] GREEN_MASK   = 8'h03,
    parameter int         YELLOW_TICKS = 1,
    parameter int         RED_TICKS    = 3,
    parameter logic [7:0] LFSR_SEED    = 8'h5A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       manual,
    input  logic       step,
    output logic [1:0] out_red_light,
    output logic       red,
    output logic       phase_pulse,
    output logic [7:0] round_count
);
    localparam logic [7:0] SEED       = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [7:0] YELLOW_LEN = 8'(YELLOW_TICKS);
    localparam logic [7:0] RED_LEN    = 8'(RED_TICKS);

    state_t     state, state_next;
    logic [7:0] lfsr, remaining, remaining_next, green_len;
    logic [8:0] green_sum;
    logic       step_flag, manual_q, tick, advance, phase_change, clear_div;

    function automatic logic [7:0] phase_len(input state_t s, input logic [7:0] glen);
        case (s)
            GREEN:   return glen;
            YELLOW:  return YELLOW_LEN;
            RED:     return RED_LEN;
            default: return 8'd0;
        endcase
    endfunction

    function automatic state_t follow(input state_t s);
        case (s)
            GREEN:   return YELLOW;
            YELLOW:  return RED;
            RED:     return GREEN;
            default: return IDLE;
        endcase
    endfunction

    // Green length saturates rather than wrapping when MIN plus the masked LFSR overflows.
    assign green_sum = 9'(GREEN_MIN) + {1'b0, lfsr & GREEN_MASK};
    assign green_len = green_sum[8] ? 8'hFF : green_sum[7:0];

    tick_divider #(
        .TICK_DIV(TICK_DIV)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .clear(clear_div),
        .tick (tick)
    );

    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        advance        = 1'b0;
        if (!enable) begin
            state_next     = IDLE;
            remaining_next = 8'd0;
        end else if (state == IDLE) begin
            state_next = GREEN;
        end else if (manual) begin
            advance = step_flag && !step;
        end else if (manual_q) begin
            remaining_next = phase_len(state, green_len);
        end else if (tick) begin
            if (remaining <= 8'd1) begin
                advance = 1'b1;
            end else begin
                remaining_next = remaining - 8'd1;
            end
        end
        if (advance) begin
            state_next = follow(state);
        end
        phase_change = (state_next != state);
        if (phase_change && state_next != IDLE) begin
            remaining_next = phase_len(state_next, green_len);
        end
    end

    // Holding the divider cleared in manual mode makes a later switch back to timed start from zero.
    assign clear_div = phase_change || manual || (state == IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            remaining     <= 8'd0;
            lfsr          <= SEED;
            step_flag     <= 1'b0;
            manual_q      <= 1'b0;
            out_red_light <= LIGHT_GREEN;
            red           <= 1'b0;
            phase_pulse   <= 1'b0;
            round_count   <= 8'd0;
        end else begin
            state         <= state_next;
            remaining     <= remaining_next;
            lfsr          <= lfsr_next(lfsr);
            step_flag     <= manual && step;
            manual_q      <= manual;
            out_red_light <= light_code(state_next);
            red           <= (state_next == RED);
            phase_pulse   <= phase_change;
            if (state == RED && state_next == GREEN) begin
                round_count <= round_count + 8'd1;
            end
        end
    end

endmodule
